// File: rtl/fir_sm_fifo.sv
// fir_sm_fifo: output stage of the FIR engine. Buffers FIR results in a small
// first-word-fall-through register FIFO, re-emits them on a master stream,
// generates tlast from the programmed length and flags tlast mismatches.
module fir_sm_fifo #(
  parameter  int pDATA_WIDTH = 32,
  parameter  int pDEPTH      = 8,
  parameter  int pLEN_WIDTH  = 11,
  localparam int AW          = $clog2(pDEPTH),
  localparam int LW          = AW + 1
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic [pLEN_WIDTH-1:0]  cfg_len,
  input  logic                   cfg_start,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   done,
  output logic                   err_tlast,
  output logic [LW-1:0]          level
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                 state_q;
  logic [pLEN_WIDTH-1:0]  len_q, in_cnt_q, out_cnt_q;
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]          level_q;
  logic                   err_q;
  logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];

  logic [pLEN_WIDTH-1:0]  last_idx;
  logic                   push, pop, in_last, out_last;

  // Handshakes and index compares, all from registered state (no s_* -> m_* path)
  always_comb begin
    last_idx  = len_q - pLEN_WIDTH'(1);
    in_last   = (in_cnt_q == last_idx);
    out_last  = (out_cnt_q == last_idx);
    s_tready  = (state_q == RUN) && (level_q < LW'(pDEPTH));
    m_tvalid  = (level_q != '0);
    m_tdata   = m_tvalid ? mem_q[rd_ptr_q] : '0;
    m_tlast   = m_tvalid && out_last;
    push      = s_tvalid && s_tready;
    pop       = m_tvalid && m_tready;
    done      = (state_q == DONE);
    err_tlast = err_q;
    level     = level_q;
  end

  // Run control: state, latched length, beat counters and sticky tlast error.
  // Starts are only taken in IDLE/DONE, where the FIFO is empty, so the counter
  // clears never collide with a push or pop.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (push) begin
        in_cnt_q <= in_cnt_q + pLEN_WIDTH'(1);
        if (s_tlast != in_last) err_q <= 1'b1;
      end
      if (pop) out_cnt_q <= out_cnt_q + pLEN_WIDTH'(1);
      case (state_q)
        IDLE, DONE: if (cfg_start) begin
          len_q     <= cfg_len;
          in_cnt_q  <= '0;
          out_cnt_q <= '0;
          err_q     <= 1'b0;
          state_q   <= (cfg_len == '0) ? DONE : RUN;
        end
        RUN:   if (push && in_last) state_q <= DRAIN;
        DRAIN: if (pop && out_last) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap on their own width
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while not covered by level
  always_ff @(posedge axis_clk) begin
    if (push) mem_q[wr_ptr_q] <= s_tdata;
  end

endmodule
